// File: rtl/farm_sensor_ctrl.sv
// Purpose : farm-road vehicle request generator for the traffic light controller.
// Latency : raw loop rise -> veh_count update in 3+DEB_CYCLES clocks; C is a Moore output of the FSM.
// Backpr. : none; C is a level held until farm green is observed, the controller consumes it at will.
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset; clears every flop, C drops at once
//   i_loop_raw      raw loop detector, asynchronous and bouncy
//   i_light_highway highway lamp code (001 green, 010 yellow, 100 red)
//   i_light_farm    farm lamp code, same encoding
//   o_c             vehicle request to the light controller
//   o_veh_count     vehicles waiting on the farm road (saturating)
//   o_light_err     sticky flag: illegal lamp code or both directions non-red
module farm_sensor_ctrl #(
  parameter int TICK_DIV        = 4,
  parameter int DEB_CYCLES      = 3,
  parameter int MIN_GREEN_TICKS = 5,
  parameter int CNT_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_loop_raw,
  input  logic [2:0]       i_light_highway,
  input  logic [2:0]       i_light_farm,
  output logic             o_c,
  output logic [CNT_W-1:0] o_veh_count,
  output logic             o_light_err
);

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int GT_W   = $clog2(MIN_GREEN_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES);
  localparam logic [GT_W-1:0]   GT_DONE   = GT_W'(MIN_GREEN_TICKS);
  localparam logic [CNT_W-1:0]  VEH_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_REQUEST = 2'd2,
    S_SERVE   = 2'd3
  } state_t;

  function automatic logic lamp_legal(input logic [2:0] code);
    return (code == LAMP_GREEN) || (code == LAMP_YELLOW) || (code == LAMP_RED);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_deb;
  logic              r_deb_d;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [GT_W-1:0]   r_green_tmr;
  logic [CNT_W-1:0]  r_veh_count;
  logic              r_light_err;
  state_t            r_state;

  logic              w_tick;
  logic              w_hwy_green;
  logic              w_farm_green;
  logic              w_arrival;
  logic              w_green_done;
  logic              w_illegal;
  logic              w_serve_entry;
  logic              w_c;
  state_t            w_next_state;

  assign w_hwy_green  = (i_light_highway == LAMP_GREEN);
  assign w_farm_green = (i_light_farm == LAMP_GREEN);

  // ---------------------------------------------------------------------------
  // 1 s tick: free-running 0..TICK_DIV-1
  // ---------------------------------------------------------------------------
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser on the asynchronous loop input
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_loop_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce. The counter tracks how long the synced level has disagreed with
  // the debounced level; any agreement restarts it, so a bounce resets the
  // qualification window. The flip happens on the edge where the counter
  // already holds DEB_CYCLES and the input still disagrees, which puts the
  // debounced rise at edge 2+DEB_CYCLES after the raw sample.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_deb     <= ~r_deb;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb_d <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
    end
  end

  // One vehicle per debounced rising edge; a held loop produces one edge only.
  assign w_arrival = r_deb & ~r_deb_d;

  // ---------------------------------------------------------------------------
  // Highway green timer: counts ticks of continuous highway green, saturating.
  // ---------------------------------------------------------------------------
  assign w_green_done = (r_green_tmr == GT_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_green_tmr <= '0;
    end else if (!w_hwy_green) begin
      r_green_tmr <= '0;
    end else if (w_tick && !w_green_done) begin
      r_green_tmr <= r_green_tmr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_c          = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Decision uses the registered count; a same-cycle arrival is picked
        // up on the following clock.
        if (r_veh_count != '0) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_farm_green) begin
          w_next_state = S_SERVE;
        end else if (w_green_done || !w_hwy_green) begin
          // Either the highway has had its minimum green, or the controller
          // is already moving off highway green and the request is free.
          w_next_state = S_REQUEST;
        end
      end
      S_REQUEST: begin
        w_c = 1'b1;
        if (w_farm_green) begin
          w_next_state = S_SERVE;
        end
      end
      S_SERVE: begin
        if (w_hwy_green) begin
          w_next_state = (r_veh_count != '0) ? S_WAIT : S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_serve_entry = (w_next_state == S_SERVE) && (r_state != S_SERVE);

  // ---------------------------------------------------------------------------
  // Vehicle counter. Entering SERVE flushes the queue of waiting vehicles and
  // beats any arrival on the same edge; arrivals while the farm lamp is green
  // drive straight through and are not queued.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_veh_count <= '0;
    end else if (w_serve_entry) begin
      r_veh_count <= '0;
    end else if (w_arrival && !w_farm_green && (r_veh_count != VEH_MAX)) begin
      r_veh_count <= r_veh_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Illegal light monitor (diagnostic only, the FSM does not react to it)
  // ---------------------------------------------------------------------------
  assign w_illegal = !lamp_legal(i_light_highway) ||
                     !lamp_legal(i_light_farm) ||
                     ((i_light_highway != LAMP_RED) && (i_light_farm != LAMP_RED));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_light_err <= 1'b0;
    end else if (w_illegal) begin
      r_light_err <= 1'b1;
    end
  end

  assign o_c         = w_c;
  assign o_veh_count = r_veh_count;
  assign o_light_err = r_light_err;

endmodule

// File: tb/tb_farm_sensor_ctrl.sv
// Bench for farm_sensor_ctrl: directed scenarios followed by randomized loop
// and light-sequence traffic, compared each cycle against a behavioural model.
module tb_farm_sensor_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int MING     = 5;
  localparam int CNT_W    = 8;
  localparam int VMAX     = (1 << CNT_W) - 1;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             raw;
  logic [2:0]       hw;
  logic [2:0]       fm;
  logic             c;
  logic [CNT_W-1:0] veh;
  logic             err;

  always #5 clk = ~clk;

  farm_sensor_ctrl #(
    .TICK_DIV(TICK_DIV),
    .DEB_CYCLES(DEB),
    .MIN_GREEN_TICKS(MING),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_loop_raw(raw),
    .i_light_highway(hw),
    .i_light_farm(fm),
    .o_c(c),
    .o_veh_count(veh),
    .o_light_err(err)
  );

  typedef struct packed {
    logic             c;
    logic [CNT_W-1:0] veh;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // ---------------- behavioural reference model ----------------
  // Phases of service for the waiting farm traffic.
  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_REQ   = 2;
  localparam int P_SERVE = 3;

  int m_edges;      // clock edges since reset release
  int m_hist[$];    // raw samples of the last two edges (synchroniser delay)
  int m_deb;        // accepted (debounced) loop level
  int m_run;        // consecutive edges the synced level disagreed
  int m_rise;       // accepted level rose on the previous edge
  int m_timer;      // seconds of continuous highway green, capped
  int m_veh;
  int m_err;
  int m_phase;

  int raw_left;
  bit rnd_raw;

  function automatic bit legal(input logic [2:0] v);
    return (v == G) || (v == Y) || (v == R);
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_hist.delete();
    m_hist.push_back(0);
    m_hist.push_back(0);
    m_deb   = 0;
    m_run   = 0;
    m_rise  = 0;
    m_timer = 0;
    m_veh   = 0;
    m_err   = 0;
    m_phase = P_IDLE;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.c   = (m_phase == P_REQ);
    e.veh = m_veh[CNT_W-1:0];
    e.err = m_err[0];
    return e;
  endfunction

  // Applies one clock edge using the inputs that were stable before it.
  task automatic model_edge();
    int synced;
    int nxt;
    int nveh;
    int ntimer;
    bit tick;
    bit hg;
    bit fg;
    bit arrive;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick   = ((m_edges % TICK_DIV) == TICK_DIV - 1);
    hg     = (hw == G);
    fg     = (fm == G);
    arrive = (m_rise != 0);

    // The level seen by the debouncer is the raw input from two edges ago.
    synced = m_hist.pop_front();
    m_hist.push_back(int'(raw));
    m_rise = 0;
    if (synced != m_deb) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_deb  = 1 - m_deb;
        m_run  = 0;
        m_rise = m_deb;
      end
    end else begin
      m_run = 0;
    end

    nxt = m_phase;
    case (m_phase)
      P_IDLE:  if (m_veh != 0) nxt = P_WAIT;
      P_WAIT:  if (fg) nxt = P_SERVE;
               else if (m_timer == MING || !hg) nxt = P_REQ;
      P_REQ:   if (fg) nxt = P_SERVE;
      default: if (hg) nxt = (m_veh != 0) ? P_WAIT : P_IDLE;
    endcase

    nveh = m_veh;
    if (nxt == P_SERVE && m_phase != P_SERVE) nveh = 0;
    else if (arrive && !fg && m_veh < VMAX) nveh = m_veh + 1;

    if (!hg) ntimer = 0;
    else if (tick && m_timer < MING) ntimer = m_timer + 1;
    else ntimer = m_timer;

    if (!legal(hw) || !legal(fm) || (hw != R && fm != R)) m_err = 1;

    m_phase = nxt;
    m_veh   = nveh;
    m_timer = ntimer;
    m_edges++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic gen_raw();
    if (raw_left <= 0) begin
      raw = ~raw;
      raw_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2))
                                             : int'($urandom_range(5, 14));
    end
    raw_left--;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_raw) gen_raw();
      tick_cycle();
    end
  endtask

  // Asserted just after a clock edge: outputs must clear before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    exp_q.push_back(model_out());
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (c !== e.c) begin
        failures++;
        $display("FAIL C t=%0t got=%0b expected=%0b", $time, c, e.c);
      end
      checks++;
      if (veh !== e.veh) begin
        failures++;
        $display("FAIL veh_count t=%0t got=%0d expected=%0d", $time, veh, e.veh);
      end
      checks++;
      if (err !== e.err) begin
        failures++;
        $display("FAIL light_err t=%0t got=%0b expected=%0b", $time, err, e.err);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n    = 1'b0;
    raw      = 1'b0;
    hw       = G;
    fm       = R;
    rnd_raw  = 1'b0;
    raw_left = 0;
    model_reset();
    run(3);
    rst_n = 1'b1;

    // Clean pulse under highway green, request after minimum green.
    raw = 1'b1; run(10);
    raw = 1'b0; run(25);

    // Serve the farm road, then return to highway green with nobody waiting.
    hw = Y; run(3);
    hw = R; run(2);
    fm = G; run(4);
    fm = Y; run(3);
    fm = R; run(1);
    hw = G; run(10);

    // Bounce is rejected, a solid press is counted once.
    raw = 1'b1; run(2);
    raw = 1'b0; run(1);
    raw = 1'b1; run(2);
    raw = 1'b0; run(8);
    raw = 1'b1; run(5);
    raw = 1'b0; run(10);

    // Saturation.
    for (int k = 0; k < 300; k++) begin
      raw = 1'b1; run(6);
      raw = 1'b0; run(6);
    end

    // Service, then an arrival during farm yellow, then re-request.
    hw = Y; run(3);
    hw = R; run(2);
    fm = G; run(4);
    fm = Y; raw = 1'b1; run(8);
    raw = 1'b0; run(4);
    fm = R; run(2);
    hw = G; run(30);

    // Illegal code sets the sticky flag; reset mid-request clears everything.
    hw = 3'b011; run(1);
    hw = G; run(5);
    do_reset(); run(2);
    rst_n = 1'b1; run(5);

    // Randomized traffic with a legal light sequence plus occasional faults.
    rnd_raw = 1'b1;
    for (int s = 0; s < 40; s++) begin
      hw = G; fm = R; run(int'($urandom_range(8, 40)));
      if ($urandom_range(0, 9) == 0) begin
        hw = 3'($urandom_range(0, 7)); run(1);
        hw = G; run(2);
      end
      if ($urandom_range(0, 9) == 0) begin
        do_reset(); run(2);
        rst_n = 1'b1; run(1);
      end
      hw = Y; run(3);
      hw = R; run(1);
      fm = G; run(int'($urandom_range(3, 12)));
      fm = Y; run(3);
      fm = R; run(1);
    end
    rnd_raw = 1'b0;
    raw = 1'b0;
    hw = G;
    run(10);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
